// File: rtl/io_rx_responder.sv
// io_rx_responder: 8N1 UART receiver with a byte FIFO that answers core IO read requests over req/ack.
module io_rx_responder #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rxd,
    input  logic                          io_req,
    output logic                          io_ack,
    output logic [31:0]                   io_rdata,
    output logic                          rx_overflow,
    output logic                          frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {RESP_IDLE, RESP_ACK} resp_state_t;

    rx_state_t   rx_state;
    resp_state_t resp_state;
    logic          rx_meta, rxs;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic          stop_tick, push, pop, accept;

    assign stop_tick = rx_state == STOP && baud == LAST;
    assign push      = stop_tick && rxs;
    assign pop       = resp_state == RESP_IDLE && io_req && fifo_count != '0;
    // a simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign accept    = push && (fifo_count != FULL || pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_state  <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_tick && !rxs;
            case (rx_state)
                IDLE:
                    if (!rxs) begin
                        rx_state <= START;
                        baud     <= '0;
                    end
                START:
                    if (baud == HALF) begin
                        rx_state <= rxs ? IDLE : DATA;
                        baud     <= '0;
                        bit_idx  <= '0;
                    end else baud <= baud + 1'b1;
                DATA:
                    if (baud == LAST) begin
                        shift[bit_idx] <= rxs;
                        baud           <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rx_state <= STOP;
                    end else baud <= baud + 1'b1;
                STOP:
                    if (baud == LAST) begin
                        rx_state <= IDLE;
                        baud     <= '0;
                    end else baud <= baud + 1'b1;
                default: rx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wp] <= shift;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp          <= '0;
            rp          <= '0;
            fifo_count  <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (accept) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(accept) - (AW+1)'(pop);
            if (push && !accept) rx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_state <= RESP_IDLE;
            io_ack     <= 1'b0;
            io_rdata   <= '0;
        end else begin
            io_ack     <= pop;
            resp_state <= pop ? RESP_ACK : RESP_IDLE;
            if (pop) io_rdata <= {24'b0, mem[rp]};
        end
    end
endmodule

// File: tb/tb_io_rx_responder.sv
// tb_io_rx_responder: directed UART frames with a scoreboard of expected bytes checked on every io_ack.
module tb_io_rx_responder;
    localparam int CPB   = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rstn = 1'b0, rxd = 1'b1, io_req = 1'b0;
    logic        io_ack, rx_overflow, frame_err;
    logic [31:0] io_rdata;
    logic [4:0]  fifo_count;

    int         checks = 0, failures = 0, fe_pulses = 0, lat = 0, f0 = 0;
    logic [7:0] exp_q[$];

    io_rx_responder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .io_req(io_req), .io_ack(io_ack),
        .io_rdata(io_rdata), .rx_overflow(rx_overflow), .frame_err(frame_err),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err) fe_pulses++;
        if (io_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ack_unexpected actual=%h required=no_ack", io_rdata);
            end else check("ack_data", io_rdata, {24'b0, exp_q.pop_front()});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv);
        @(negedge clk) rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(CPB);
        end
        rxd = stopv;
        idle(CPB);
        rxd = 1'b1;
    endtask

    task automatic req_byte(output int l);
        @(negedge clk) io_req = 1'b1;
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!io_ack && l < 300);
        if (!io_ack) begin
            failures++;
            $display("FAIL ack_timeout actual=no_ack required=ack");
        end
        io_req = 1'b0;
        @(negedge clk);
        check("ack_width", io_ack, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        idle(4);
        rstn = 1'b1;
        idle(1);
        check("rst_ack", io_ack, 0);
        check("rst_rdata", io_rdata, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", rx_overflow, 0);
        check("rst_ferr", frame_err, 0);

        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("t1_count_pre", fifo_count, 1);
        req_byte(lat);
        check("t1_latency", lat, 1);
        check("t1_count_post", fifo_count, 0);
        idle(5);
        check("t1_rdata_hold", io_rdata, 32'hA5);

        exp_q.push_back(8'h3C);
        fork
            send_frame(8'h3C, 1'b1);
            req_byte(lat);
        join
        check("t2_latency", lat, 80);

        for (int i = 1; i <= DEPTH + 1; i++) begin
            if (i <= DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            if (i == DEPTH) begin
                check("t3_count_full", fifo_count, DEPTH);
                check("t3_ovf_before", rx_overflow, 0);
            end
        end
        check("t3_count_after", fifo_count, DEPTH);
        check("t3_ovf_after", rx_overflow, 1);
        for (int i = 0; i < DEPTH; i++) req_byte(lat);
        check("t3_count_drained", fifo_count, 0);
        check("t3_queue_drained", exp_q.size(), 0);

        f0 = fe_pulses;
        send_frame(8'h77, 1'b0);
        idle(12);
        check("t4_ferr_pulses", fe_pulses - f0, 1);
        check("t4_count", fifo_count, 0);
        exp_q.push_back(8'h78);
        send_frame(8'h78, 1'b1);
        req_byte(lat);

        f0 = fe_pulses;
        @(negedge clk) rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(40);
        check("t5_count", fifo_count, 0);
        check("t5_ferr", fe_pulses - f0, 0);

        send_frame(8'h99, 1'b1);
        check("t6_count_pre", fifo_count, 1);
        check("t6_ovf_pre", rx_overflow, 1);
        @(negedge clk) rxd = 1'b0;
        idle(20);
        io_req = 1'b1;
        rstn = 1'b0;
        idle(3);
        rstn = 1'b1;
        rxd = 1'b1;
        idle(2);
        check("t6_count", fifo_count, 0);
        check("t6_ack", io_ack, 0);
        check("t6_ovf", rx_overflow, 0);
        check("t6_rdata", io_rdata, 0);
        idle(20);
        io_req = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        req_byte(lat);
        check("t6_latency", lat, 1);

        idle(5);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
